myip_adc_tap_mc: RTL and testbench

MYIP_ADC_TAP_MC -- requirements
Module: myip_adc_tap_mc

---
 rtl/myip_adc_tap_mc_if.sv | 30 +++
 rtl/myip_adc_tap_mc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_myip_adc_tap_mc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/myip_adc_tap_mc_if.sv
// AXI4-Lite bus bundle for the multi-channel ADC tap (6-bit address, 32-bit data).
interface myip_adc_tap_mc_if;
    logic [5:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/myip_adc_tap_mc.sv
// Multi-channel ADC tap: per-channel hold registers drained round-robin into a sample FIFO,
// AXI4-Lite CSRs and a level interrupt. Define ADC_TAP_THRESH_EN for per-channel threshold IRQs.
module myip_adc_tap_mc #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    myip_adc_tap_mc_if.slave         s_axi,
    input  logic [NUM_CH-1:0]        adc_valid,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    output logic                     irq
);
    localparam int unsigned ISR_W = NUM_CH + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned ENT_W = 3 + DATA_W;

    localparam logic [3:0] A_GIE    = 4'h0;
    localparam logic [3:0] A_IER    = 4'h1;
    localparam logic [3:0] A_CTRL   = 4'h2;
    localparam logic [3:0] A_ACK    = 4'h3;
    localparam logic [3:0] A_ISR    = 4'h4;
    localparam logic [3:0] A_WMARK  = 4'h5;
    localparam logic [3:0] A_THRESH = 4'h6;
    localparam logic [3:0] A_FIFO   = 4'h7;
    localparam logic [3:0] A_STATUS = 4'h8;

    // AXI channel state
    logic        aw_rdy;
    logic        b_vld;
    logic        ar_rdy;
    logic        r_vld;
    logic [31:0] r_data;
    logic        wr_fire_c;
    logic        rd_fire_c;
    logic [3:0]  wr_sel_c;
    logic [3:0]  rd_sel_c;
    logic        axi_unused;

    // CSRs
    logic              gie;
    logic [ISR_W-1:0]  ier;
    logic [ISR_W-1:0]  isr;
    logic [NUM_CH-1:0] en_mask;
    logic [7:0]        wmark;
`ifdef ADC_TAP_THRESH_EN
    logic [DATA_W-1:0] thresh;
`endif

    // Capture, arbitration and FIFO
    logic [NUM_CH-1:0] hold_full;
    logic [DATA_W-1:0] hold_data [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_empty_c;
    logic              fifo_full_c;
    logic              flush_c;
    logic              push_c;
    logic              pop_c;
    logic              gnt_vld_c;
    logic [CH_W-1:0]   gnt_ch_c;
    int unsigned       rr_idx_c;
    logic [NUM_CH-1:0] cap_c;
    logic              ovf_c;
    logic [ISR_W-1:0]  ack_c;
    logic [ISR_W-1:0]  isr_set_c;
    logic [31:0]       fifo_word_c;
    logic [31:0]       status_c;
    logic [31:0]       rd_mux_c;

    assign s_axi.AWREADY = aw_rdy;
    assign s_axi.WREADY  = aw_rdy;
    assign s_axi.BVALID  = b_vld;
    assign s_axi.BRESP   = 2'b00;
    assign s_axi.ARREADY = ar_rdy;
    assign s_axi.RVALID  = r_vld;
    assign s_axi.RDATA   = r_data;
    assign s_axi.RRESP   = 2'b00;

    assign axi_unused = ^{s_axi.WSTRB, s_axi.WDATA, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

    assign wr_fire_c = aw_rdy & s_axi.AWVALID & s_axi.WVALID;
    assign rd_fire_c = ar_rdy & s_axi.ARVALID;
    assign wr_sel_c  = s_axi.AWADDR[5:2];
    assign rd_sel_c  = s_axi.ARADDR[5:2];

    assign fifo_empty_c = (count == '0);
    assign fifo_full_c  = (count == CNT_W'(FIFO_DEPTH));
    assign flush_c      = wr_fire_c && (wr_sel_c == A_CTRL) && s_axi.WDATA[31];
    assign push_c       = gnt_vld_c && !fifo_full_c && !flush_c;
    assign pop_c        = rd_fire_c && (rd_sel_c == A_FIFO) && !fifo_empty_c;
    assign ack_c        = (wr_fire_c && (wr_sel_c == A_ACK)) ? s_axi.WDATA[ISR_W-1:0] : '0;

    // Ready is a one-cycle pulse so each address/data pair is taken exactly once
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            aw_rdy <= !aw_rdy && !b_vld && s_axi.AWVALID && s_axi.WVALID;
            if (wr_fire_c)         b_vld <= 1'b1;
            else if (s_axi.BREADY) b_vld <= 1'b0;
            ar_rdy <= !ar_rdy && !r_vld && s_axi.ARVALID;
            if (rd_fire_c) begin
                r_vld  <= 1'b1;
                r_data <= rd_mux_c;
            end else if (s_axi.RREADY) begin
                r_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gie     <= 1'b0;
            ier     <= '0;
            en_mask <= '0;
            wmark   <= '0;
`ifdef ADC_TAP_THRESH_EN
            thresh  <= '0;
`endif
        end else if (wr_fire_c) begin
            case (wr_sel_c)
                A_GIE:    gie     <= s_axi.WDATA[0];
                A_IER:    ier     <= s_axi.WDATA[ISR_W-1:0];
                A_CTRL:   en_mask <= s_axi.WDATA[NUM_CH-1:0];
                A_WMARK:  wmark   <= s_axi.WDATA[7:0];
`ifdef ADC_TAP_THRESH_EN
                A_THRESH: thresh  <= s_axi.WDATA[DATA_W-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Round-robin search begins at rr_ptr; lowest offset from it wins
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_ch_c  = '0;
        rr_idx_c  = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            rr_idx_c = 32'(rr_ptr) + 32'(i);
            if (rr_idx_c >= NUM_CH) rr_idx_c = rr_idx_c - NUM_CH;
            if (hold_full[CH_W'(rr_idx_c)]) begin
                gnt_vld_c = 1'b1;
                gnt_ch_c  = CH_W'(rr_idx_c);
            end
        end
    end

    // A hold being drained this cycle is not counted as overwritten
    always_comb begin
        cap_c = adc_valid & en_mask;
        ovf_c = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cap_c[c] && hold_full[c] && !(push_c && (gnt_ch_c == CH_W'(c)))) ovf_c = 1'b1;
        end
    end

    always_comb begin
        isr_set_c    = '0;
        isr_set_c[0] = (wmark != 8'd0) && (32'(count) >= 32'(wmark));
        isr_set_c[1] = ovf_c;
`ifdef ADC_TAP_THRESH_EN
        for (int c = 0; c < NUM_CH; c++) begin
            isr_set_c[2+c] = cap_c[c] && (adc_data[c*DATA_W +: DATA_W] > thresh);
        end
`endif
    end

    // Set has priority over a same-cycle acknowledge
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            isr <= '0;
            irq <= 1'b0;
        end else begin
            isr <= (isr & ~ack_c) | isr_set_c;
            irq <= gie && (|(isr & ier));
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            hold_full <= '0;
            rr_ptr    <= '0;
            for (int c = 0; c < NUM_CH; c++) hold_data[c] <= '0;
        end else begin
            if (push_c) rr_ptr <= (gnt_ch_c == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch_c + CH_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush_c) begin
                    hold_full[c] <= 1'b0;
                end else if (cap_c[c]) begin
                    hold_full[c] <= 1'b1;
                    hold_data[c] <= adc_data[c*DATA_W +: DATA_W];
                end else if (push_c && (gnt_ch_c == CH_W'(c))) begin
                    hold_full[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage only; validity is tracked by the pointers
    always_ff @(posedge ACLK) begin
        if (push_c) fifo_mem[wr_ptr] <= {3'(gnt_ch_c), hold_data[gnt_ch_c]};
    end

    always_comb begin
        fifo_word_c                = '0;
        fifo_word_c[31]            = 1'b1;
        fifo_word_c[26:24]         = fifo_mem[rd_ptr][ENT_W-1 -: 3];
        fifo_word_c[DATA_W-1:0]    = fifo_mem[rd_ptr][DATA_W-1:0];
        status_c                   = '0;
        status_c[8:0]              = 9'(count);
        status_c[16]               = fifo_empty_c;
        status_c[17]               = fifo_full_c;
        rd_mux_c                   = '0;
        case (rd_sel_c)
            A_GIE:    rd_mux_c = 32'(gie);
            A_IER:    rd_mux_c = 32'(ier);
            A_CTRL:   rd_mux_c = 32'(en_mask);
            A_ISR:    rd_mux_c = 32'(isr);
            A_WMARK:  rd_mux_c = 32'(wmark);
`ifdef ADC_TAP_THRESH_EN
            A_THRESH: rd_mux_c = 32'(thresh);
`endif
            A_FIFO:   rd_mux_c = fifo_empty_c ? 32'h0 : fifo_word_c;
            A_STATUS: rd_mux_c = status_c;
            default:  rd_mux_c = '0;
        endcase
    end
endmodule

// File: tb/tb_myip_adc_tap_mc.sv
// Scoreboard bench for myip_adc_tap_mc: reads queue expected data, a monitor checks RDATA.
module tb_myip_adc_tap_mc;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned FIFO_DEPTH = 16;

    localparam logic [5:0] R_GIE    = 6'h00;
    localparam logic [5:0] R_IER    = 6'h04;
    localparam logic [5:0] R_CTRL   = 6'h08;
    localparam logic [5:0] R_ACK    = 6'h0C;
    localparam logic [5:0] R_ISR    = 6'h10;
    localparam logic [5:0] R_WMARK  = 6'h14;
    localparam logic [5:0] R_THRESH = 6'h18;
    localparam logic [5:0] R_FIFO   = 6'h1C;
    localparam logic [5:0] R_STATUS = 6'h20;

    logic                     aclk   = 1'b0;
    logic                     areset = 1'b1;
    logic [NUM_CH-1:0]        adc_valid;
    logic [NUM_CH*DATA_W-1:0] adc_data;
    logic                     irq;

    myip_adc_tap_mc_if bus();

    myip_adc_tap_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ACLK      (aclk),
        .ARESET    (areset),
        .s_axi     (bus),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .irq       (irq)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mask_q [$];
    string       name_q [$];
    logic [31:0] mon_exp;
    logic [31:0] mon_mask;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed read beat is matched against the oldest expectation
    always @(negedge aclk) begin
        if (!areset && bus.RVALID && bus.RREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", bus.RDATA);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_mask = mask_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, bus.RDATA & mon_mask, mon_exp & mon_mask);
            end
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
        int k;
        @(negedge aclk);
        bus.AWADDR  = a;
        bus.WDATA   = d;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (!bus.AWREADY && k < 50);
        if (!bus.AWREADY) begin
            checks++;
            errors++;
            $display("FAIL aw_timeout: got AWREADY=0 expected 1 addr 0x%02h", a);
        end else begin
            @(posedge aclk);
        end
        #1;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] e, input logic [31:0] m,
                            input string n);
        int k;
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(n);
        @(negedge aclk);
        bus.ARADDR  = a;
        bus.ARVALID = 1'b1;
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (!bus.ARREADY && k < 50);
        if (!bus.ARREADY) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout %s: got ARREADY=0 expected 1", n);
            void'(exp_q.pop_back());
            void'(mask_q.pop_back());
            void'(name_q.pop_back());
            bus.ARVALID = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        bus.ARVALID = 1'b0;
        @(negedge aclk);
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d);
        @(negedge aclk);
        adc_valid = v;
        adc_data  = d;
        @(negedge aclk);
        adc_valid = '0;
    endtask

    task automatic strobe_ch(input int c, input logic [DATA_W-1:0] val);
        logic [NUM_CH-1:0]        v;
        logic [NUM_CH*DATA_W-1:0] d;
        v = '0;
        d = '0;
        v[c] = 1'b1;
        d[c*DATA_W +: DATA_W] = val;
        strobe(v, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        adc_valid   = '0;
        adc_data    = '0;
        bus.AWADDR  = '0;
        bus.WDATA   = '0;
        bus.WSTRB   = 4'hF;
        bus.ARADDR  = '0;
        bus.BREADY  = 1'b1;
        bus.RREADY  = 1'b1;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        bus.ARVALID = 1'b1;

        // Reset holds every handshake output low even with requests pending
        repeat (3) @(negedge aclk);
        check("rst_irq",     32'(irq),         32'h0);
        check("rst_awready", 32'(bus.AWREADY), 32'h0);
        check("rst_wready",  32'(bus.WREADY),  32'h0);
        check("rst_arready", 32'(bus.ARREADY), 32'h0);
        check("rst_bvalid",  32'(bus.BVALID),  32'h0);
        check("rst_rvalid",  32'(bus.RVALID),  32'h0);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        areset      = 1'b0;
        axi_read(R_STATUS, 32'h0001_0000, 32'hFFFF_FFFF, "rst_status");
        axi_read(R_ISR,    32'h0,         32'hFFFF_FFFF, "rst_isr");

        // All four channels in one cycle drain in channel order
        axi_write(R_CTRL, 32'hF);
        strobe(4'hF, {12'hD33, 12'hC22, 12'hB11, 12'hA00});
        repeat (6) @(negedge aclk);
        axi_read(R_STATUS, 32'h0000_0004, 32'hFFFF_FFFF, "all_ch_count");
        axi_read(R_ISR,    32'h0,         32'h3,         "all_ch_no_ovf");
        axi_read(R_FIFO,   32'h8000_0A00, 32'hFFFF_FFFF, "all_ch_pop0");
        axi_read(R_FIFO,   32'h8100_0B11, 32'hFFFF_FFFF, "all_ch_pop1");
        axi_read(R_FIFO,   32'h8200_0C22, 32'hFFFF_FFFF, "all_ch_pop2");
        axi_read(R_FIFO,   32'h8300_0D33, 32'hFFFF_FFFF, "all_ch_pop3");
        axi_write(R_ACK, 32'hFFFF_FFFF);

        // Watermark interrupt path
        axi_write(R_GIE,   32'h1);
        axi_write(R_IER,   32'h1);
        axi_write(R_WMARK, 32'h2);
        axi_write(R_CTRL,  32'h1);
        strobe_ch(0, 12'h123);
        strobe_ch(0, 12'h456);
        repeat (4) @(negedge aclk);
        check("wmark_irq_high", 32'(irq), 32'h1);
        axi_read(R_STATUS, 32'h0000_0002, 32'hFFFF_FFFF, "wmark_count");
        axi_read(R_FIFO,   32'h8000_0123, 32'hFFFF_FFFF, "wmark_pop0");
        axi_read(R_FIFO,   32'h8000_0456, 32'hFFFF_FFFF, "wmark_pop1");
        axi_read(R_ISR,    32'h1,         32'h3,         "wmark_isr_sticky");
        axi_write(R_ACK, 32'h1);
        axi_read(R_ISR,    32'h0,         32'h3,         "wmark_isr_acked");
        repeat (2) @(negedge aclk);
        check("wmark_irq_low", 32'(irq), 32'h0);

        // Empty FIFO read
        axi_read(R_FIFO,   32'h0,         32'hFFFF_FFFF, "empty_fifo_data");
        axi_read(R_STATUS, 32'h0001_0000, 32'hFFFF_FFFF, "empty_status");

        // Full FIFO stalls ch2 hold; second ch2 strobe overwrites it
        axi_write(R_CTRL, 32'h5);
        for (int i = 0; i < 16; i++) strobe_ch(0, 12'(12'h300 + i));
        repeat (4) @(negedge aclk);
        axi_read(R_STATUS, 32'h0002_0010, 32'hFFFF_FFFF, "full_status");
        strobe_ch(2, 12'h111);
        strobe_ch(2, 12'h222);
        repeat (2) @(negedge aclk);
        axi_read(R_ISR,    32'h2,         32'h2,         "ovf_isr");
        axi_read(R_FIFO,   32'h8000_0300, 32'hFFFF_FFFF, "full_pop_first");
        repeat (2) @(negedge aclk);
        axi_read(R_STATUS, 32'h0002_0010, 32'hFFFF_FFFF, "refill_status");
        for (int i = 1; i < 16; i++) axi_read(R_FIFO, 32'h8000_0300 + 32'(i), 32'hFFFF_FFFF, "full_pop_ch0");
        axi_read(R_FIFO,   32'h8200_0222, 32'hFFFF_FFFF, "ovf_second_sample");
        axi_read(R_STATUS, 32'h0001_0000, 32'hFFFF_FFFF, "drained_status");

        // Read-only and unmapped addresses
        axi_write(R_WMARK, 32'h0);
        axi_write(R_ACK,   32'hFFFF_FFFF);
        axi_write(R_ISR,   32'h3F);
        axi_read(R_ISR,    32'h0,         32'hFFFF_FFFF, "isr_ro");
        axi_read(6'h24,    32'h0,         32'hFFFF_FFFF, "unmapped_read");

        // Threshold compare, strictly greater
        axi_write(R_THRESH, 32'h800);
        axi_write(R_CTRL,   32'h2);
        strobe_ch(1, 12'h800);
        repeat (3) @(negedge aclk);
        axi_read(R_ISR, 32'h0, 32'hFFFF_FFFF, "thresh_equal");
        strobe_ch(1, 12'h801);
        repeat (3) @(negedge aclk);
`ifdef ADC_TAP_THRESH_EN
        axi_read(R_THRESH, 32'h800, 32'hFFFF_FFFF, "thresh_reg");
        axi_read(R_ISR,    32'h8,   32'hFFFF_FFFF, "thresh_above");
`else
        axi_read(R_THRESH, 32'h0,   32'hFFFF_FFFF, "thresh_reg");
        axi_read(R_ISR,    32'h0,   32'hFFFF_FFFF, "thresh_above");
`endif
        axi_read(R_STATUS, 32'h0000_0002, 32'hFFFF_FFFF, "thresh_count");
        axi_write(R_CTRL, 32'h8000_0002);
        axi_read(R_STATUS, 32'h0001_0000, 32'hFFFF_FFFF, "flush_status");
        axi_read(R_CTRL,   32'h0000_0002, 32'hFFFF_FFFF, "flush_bit_reads0");

        // Reset in the middle of a write with a populated FIFO
        axi_write(R_ACK,   32'hFFFF_FFFF);
        axi_write(R_WMARK, 32'h2);
        axi_write(R_CTRL,  32'h1);
        for (int i = 0; i < 5; i++) strobe_ch(0, 12'(12'h050 + i));
        repeat (4) @(negedge aclk);
        check("pre_rst_irq", 32'(irq), 32'h1);
        axi_read(R_STATUS, 32'h0000_0005, 32'hFFFF_FFFF, "pre_rst_count");
        @(negedge aclk);
        bus.BREADY  = 1'b0;
        bus.AWADDR  = R_WMARK;
        bus.WDATA   = 32'h9;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (!bus.AWREADY && k < 50);
        @(posedge aclk);
        #1;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        @(negedge aclk);
        check("mid_write_bvalid", 32'(bus.BVALID), 32'h1);
        areset = 1'b1;
        @(negedge aclk);
        check("rst_drop_bvalid", 32'(bus.BVALID), 32'h0);
        check("rst_drop_irq",    32'(irq),        32'h0);
        areset     = 1'b0;
        bus.BREADY = 1'b1;
        repeat (2) @(negedge aclk);
        check("post_rst_bvalid", 32'(bus.BVALID), 32'h0);
        axi_read(R_STATUS, 32'h0001_0000, 32'hFFFF_FFFF, "post_rst_status");
        axi_read(R_ISR,    32'h0,         32'hFFFF_FFFF, "post_rst_isr");
        axi_read(R_WMARK,  32'h0,         32'hFFFF_FFFF, "post_rst_wmark");
        axi_read(R_GIE,    32'h0,         32'hFFFF_FFFF, "post_rst_gie");

        repeat (5) @(negedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
